// File: rtl/mem_responder.sv
// Fixed-latency single-outstanding memory responder: word-wide storage split into
// four byte lanes, IDLE/BUSY/DONE handshake, sticky out-of-range error flag.

module mem_responder_lane #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic          i_zero,
  input  logic [AW-1:0] i_idx,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [WORDS];
  logic [7:0] r_rdata;

  // Storage is deliberately left out of reset so contents survive a reset.
  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[i_idx] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= 8'h00;
    else if (i_rd) r_rdata <= i_zero ? 8'h00 : r_mem[i_idx];
  end

  assign o_rdata = r_rdata;
endmodule

module mem_responder #(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  input  logic            mem_write_en,
  input  logic            mem_req,
  output logic [0:3][7:0] mem_data_out,
  output logic            mem_ready,
  output logic            mem_busy,
  output logic            mem_error
);
  localparam int AW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_idx;
  logic            r_oor, r_we, r_err;
  logic [0:3][7:0] r_wdata;
  logic            w_accept, w_complete, w_oor, w_wr, w_rd;

  assign w_oor      = (mem_addr >> (AW + 2)) != 32'd0;
  assign w_accept   = mem_req && (r_state != BUSY);
  assign w_complete = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_wr       = w_complete && r_we && !r_oor;
  assign w_rd       = w_complete && !r_we;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (mem_req) w_next = BUSY;
      BUSY:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    w_next = mem_req ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept)                          r_cnt <= 4'(LATENCY - 1);
      else if (r_state == BUSY && r_cnt != 0) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request fields are captured only at acceptance; inputs are don't-care otherwise.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_idx   <= '0;
      r_oor   <= 1'b0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_idx   <= mem_addr[AW+1:2];
      r_oor   <= w_oor;
      r_we    <= mem_write_en;
      r_wdata <= mem_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b)                   r_err <= 1'b0;
    else if (w_complete && r_oor) r_err <= 1'b1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    mem_responder_lane #(.WORDS(WORDS), .AW(AW)) u_lane (
      .i_clk   (clk),
      .i_rst   (rst_b),
      .i_wr    (w_wr),
      .i_rd    (w_rd),
      .i_zero  (r_oor),
      .i_idx   (r_idx),
      .i_wdata (r_wdata[g]),
      .o_rdata (mem_data_out[g])
    );
  end

  assign mem_ready = (r_state == DONE);
  assign mem_busy  = (r_state == BUSY);
  assign mem_error = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: timing/data model based on absolute completion times,
// directed scenarios with literal expectations, then randomized traffic.

module tb_mem_responder;
  localparam int WORDS = 1024, LATENCY = 4;

  logic clk = 0, rst_b = 0;
  logic [31:0] mem_addr = 0;
  logic [0:3][7:0] mem_data_in = '0;
  logic mem_write_en = 0, mem_req = 0;
  logic [0:3][7:0] mem_data_out;
  logic mem_ready, mem_busy, mem_error;

  int errors = 0, checks = 0;
  bit run_chk = 0;

  always #5 clk = ~clk;

  mem_responder #(.WORDS(WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_b(rst_b), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_req(mem_req), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_error(mem_error)
  );

  // Model: a request accepted at edge c completes at edge c+LATENCY.
  int cyc = 0, done_at = 0, nacc = 0, p_idx = 0;
  bit pend = 0, m_ready = 0, m_err = 0, m_dknown = 1, p_we = 0, p_oor = 0;
  logic [31:0] m_dout = 0, p_data = 0;
  logic [31:0] mem_m [int];

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      pend = 0; m_ready = 0; m_err = 0; m_dout = 0; m_dknown = 1;
    end else begin
      cyc++;
      m_ready = 0;
      if (pend && cyc == done_at) begin
        pend = 0; m_ready = 1;
        if (p_oor) m_err = 1;
        if (p_we) begin
          if (!p_oor) mem_m[p_idx] = p_data;
        end else if (p_oor) begin
          m_dout = 0; m_dknown = 1;
        end else if (mem_m.exists(p_idx)) begin
          m_dout = mem_m[p_idx]; m_dknown = 1;
        end else m_dknown = 0;
      end else if (mem_req && !pend) begin
        pend = 1; done_at = cyc + LATENCY; nacc++;
        p_we = mem_write_en; p_data = mem_data_in;
        p_oor = (mem_addr / (WORDS * 4)) != 0;
        p_idx = int'((mem_addr / 4) % WORDS);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (run_chk) begin
    check("ready", 32'(mem_ready), 32'(m_ready));
    check("busy",  32'(mem_busy),  32'(pend));
    check("error", 32'(mem_error), 32'(m_err));
    if (m_dknown) check("dout", mem_data_out, m_dout);
  end

  task automatic drive(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    mem_req = req; mem_write_en = we; mem_addr = a; mem_data_in = d;
  endtask

  // Called just after the accepting edge; counts negedges until ready.
  task automatic wait_ready(input string nm);
    int lat;
    lat = 0;
    for (int i = 0; i < LATENCY + 6; i++) begin
      @(negedge clk); lat++;
      if (mem_ready) break;
    end
    check(nm, 32'(lat), 32'(LATENCY + 1));
  endtask

  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #2 drive(1, we, a, d);
    @(posedge clk); #2 drive(0, 0, $urandom, $urandom);
    wait_ready("latency");
  endtask

  initial begin
    int nr;
    logic [31:0] a;
    rst_b = 1;
    #1 run_chk = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", mem_data_out, 32'h0);
    check("rst_busy", 32'(mem_busy), 32'h0);

    // Request present on the first edge after reset release.
    @(posedge clk); #2 rst_b = 0; drive(1, 1, 32'h10, 32'h11223344);
    @(posedge clk); #2 drive(0, 0, 0, 0);
    wait_ready("first_latency");

    xact(0, 32'h10, 32'hFFFFFFFF);
    check("rd10", mem_data_out, 32'h11223344);
    check("rd10_lane0", 32'(mem_data_out[0]), 32'h11);
    repeat (3) @(negedge clk);
    check("rd10_hold", mem_data_out, 32'h11223344);

    xact(0, 32'h13, 32'h0);
    check("rd13", mem_data_out, 32'h11223344);

    // Held request alternating write/read of 0x20.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2
      mem_req = 1; mem_write_en = (nacc % 2 == 0); mem_addr = 32'h20; mem_data_in = $urandom;
    end
    @(posedge clk); #2 drive(0, 0, 0, 0);
    repeat (LATENCY + 3) @(posedge clk);

    // Requests during BUSY must be ignored.
    @(posedge clk); #2 drive(1, 1, 32'h0, 32'hA5A50F0F);
    @(posedge clk); #2 mem_req = 1;
    nr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); if (mem_ready) nr++;
      @(posedge clk); #2 mem_req = (i < 3);
    end
    check("busy_pulse_readies", 32'(nr), 32'd1);

    // Out-of-range accesses.
    xact(1, 32'h1000, 32'hDEADBEEF);
    check("oor_err_w", 32'(mem_error), 32'h1);
    xact(0, 32'h1000, 32'h0);
    check("oor_rd", mem_data_out, 32'h0);
    xact(0, 32'h0, 32'h0);
    check("word0_kept", mem_data_out, 32'hA5A50F0F);

    // Reset in the middle of a write.
    xact(1, 32'h40, 32'hCAFE0040);
    @(posedge clk); #2 drive(1, 1, 32'h40, 32'h0BAD0BAD);
    @(posedge clk); #2 drive(0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk); #2 rst_b = 1;
    #1;
    check("midrst_busy", 32'(mem_busy), 32'h0);
    check("midrst_err", 32'(mem_error), 32'h0);
    check("midrst_dout", mem_data_out, 32'h0);
    @(posedge clk); #2 rst_b = 0;
    nr = 0;
    repeat (8) begin @(negedge clk); if (mem_ready) nr++; end
    check("midrst_no_ready", 32'(nr), 32'd0);
    xact(0, 32'h40, 32'h0);
    check("rd40_prior", mem_data_out, 32'hCAFE0040);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2
      a = 32'(($urandom % 20) * 4 + $urandom % 4);
      if ($urandom % 16 == 0) a = a | (32'(1) << (12 + $urandom % 20));
      drive($urandom % 2 == 0, $urandom % 2 == 1, a, $urandom);
    end
    @(posedge clk); #2 drive(0, 0, 0, 0);
    repeat (LATENCY + 3) @(posedge clk);
    @(negedge clk);
    run_chk = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
